soc_system_step_gen: RTL
========================

# soc_system_step_gen

Avalon-MM writable step/direction pulse generator for one stepper axis. It is the output-side counterpart of the endstop input port on the HPS lightweight bridge. Software writes direction, half-period and step count. The block then emits exactly that many step pulses on `step_out` with programmable timing, and reports busy/done/remaining through a registered read path.

## Interface
- `COUNT_W`, 16: width of step count / remaining counter.
- `PERIOD_W`, 16: width of half-period register (clock cycles).
- `DIR_SETUP`, 4: cycles between move start and first step rising edge (dir setup time); 0 allowed.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select; qualifies `write`.
- `write`  in  1  write strobe, sampled when `chipselect`=1.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `step_out`  out  1  step pulse to driver.
- `dir_out`  out  1  direction to driver.
- `enable_out`  out  1  driver enable (level, 1 = enabled).

## Operation
- Register map (word addresses):
  - 0 CTRL/STATUS. Write: bit0 `dir`, bit1 `enable`, bit3 W1C `done`. Read: bit0 `dir_out`, bit1 `enable_out`, bit2 `busy`, bit3 `done`, others 0.
  - 1 HALF: write/read `half[PERIOD_W-1:0]`; value 0 treated as 1.
  - 2 COUNT: write N starts a move; read returns `remaining`.
  - 3 ABORT: any write aborts; read returns `steps_done`.
- FSM states: IDLE, SETUP, HIGH, LOW.
  - IDLE → SETUP on COUNT write with N≠0 and `enable_out`=1. If DIR_SETUP=0, go directly to HIGH.
  - Move start: latch `dir_out` from the CTRL dir bit, `remaining`←N, `steps_done`←0, `done`←0.
  - SETUP → HIGH after DIR_SETUP cycles.
  - HIGH → LOW after `half` cycles. At the HIGH→LOW transition: `remaining`−1, `steps_done`+1.
  - LOW → HIGH after `half` cycles if `remaining`≠0; else → IDLE and set `done`.
- `step_out` = 1 only in HIGH.
- `busy` = state≠IDLE.
- Boundary rules:
  - COUNT write with N=0, or with `enable`=0: no move, `done` unchanged.
  - COUNT or HALF write while busy: ignored, including the `remaining` value.
  - CTRL dir write while busy: updates the stored dir bit only; `dir_out` stays latched until the next move start. CTRL `enable` write while busy: takes effect immediately on `enable_out`.
  - Clearing `enable` while busy acts as ABORT.
  - ABORT in any state: next edge `step_out`=0, state IDLE, `remaining`←0, `done`←1, `steps_done` holds completed steps. ABORT in IDLE sets `done`.
  - ABORT and W1C `done` cannot coincide (different addresses).
  - Completion and a W1C `done` in the same cycle: `done` ends at 1 (set wins).
  - Counters saturate-free: `remaining` never underflows, because LOW checks for 0.

## Timing
- Reset values: `readdata`=0, `step_out`=0, `dir_out`=0, `enable_out`=0, `half`=1, `remaining`=0, `steps_done`=0, `done`=0, state IDLE.
- Reset asserted mid-move: all of the above on the next edge; no partial pulse extension.
- Write timing: a write sampled at edge k takes effect in registers at edge k.
- Read timing: `readdata` is updated every edge from `address` (1-cycle read latency).
- Move timing, for a COUNT write sampled at edge k with S=DIR_SETUP and H=`half`:
  - `busy` reads 1 from edge k+1.
  - `step_out` rises at k+1+S, falls at k+1+S+H, and rises again at k+1+S+2H.
  - `busy`=0 and `done`=1 at edge k+1+S+2HN.
  - Total duration S+2HN cycles.
- Outputs are registered; no combinational path from bus inputs to pins.

## Structure
- Shared package `soc_system_step_gen_pkg`:
  - state enum (IDLE/SETUP/HIGH/LOW);
  - register address constants (ADDR_CTRL=0, ADDR_HALF=1, ADDR_COUNT=2, ADDR_ABORT=3);
  - CTRL bit positions.
- Sub-module `soc_system_step_phase_timer`: loadable down-counter of PERIOD_W bits with `load`, `value`, and one-cycle `expire` pulse. It times the SETUP, HIGH and LOW phases. Everything else (register file, FSM, read mux) lives in the top module.

## Test plan
- Reset, then read all 4 addresses → `readdata` 0, 1, 0, 0 respectively; all pins 0.
- CTRL=0x3, HALF=5, COUNT=3 with DIR_SETUP=4 → `dir_out`=1; `step_out` rises 5 edges after the COUNT write; 3 pulses, each 5 high / 5 low; `done`=1 at edge +35; `remaining`=0; `steps_done`=3.
- HALF=0, COUNT=2 → pulses 1 high / 1 low; completion at +1+S+4.
- Mid-move (after 2 of 10 steps, during HIGH) write ABORT → `step_out`=0 next edge; `busy`=0, `done`=1, `steps_done`=2.
- While busy: write COUNT=7 and CTRL dir=0 → move finishes with the original N; `dir_out` unchanged until the next start, then 0.
- COUNT=4 with `enable`=0 → no pulses, `busy` stays 0. Then assert `reset` mid-move → all outputs 0 on the next edge.

Source files
------------

// File: rtl/soc_system_step_gen_pkg.sv
// Shared types and constants for the stepper step/direction generator.
package soc_system_step_gen_pkg;

  // Move sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  // Avalon-MM word addresses.
  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_HALF  = 2'd1;
  localparam logic [1:0] ADDR_COUNT = 2'd2;
  localparam logic [1:0] ADDR_ABORT = 2'd3;

  // CTRL/STATUS bit positions.
  localparam int CTRL_DIR_BIT  = 0;
  localparam int CTRL_EN_BIT   = 1;
  localparam int CTRL_BUSY_BIT = 2;
  localparam int CTRL_DONE_BIT = 3;

endpackage

// File: rtl/soc_system_step_phase_timer.sv
// Loadable down-counter timing one sequencer phase. Loading value V (V >= 1)
// on an edge makes expire high during the cycle before the V-th edge after it,
// so a consumer that acts on expire changes phase exactly V edges later.
module soc_system_step_phase_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [PERIOD_W-1:0] value,
  output logic                expire
);

  logic [PERIOD_W-1:0] cnt;
  logic                running;

  assign expire = running && (cnt == '0);

  // Count down the loaded phase length; stop after the single expire cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      cnt     <= value - PERIOD_W'(1);
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) begin
        running <= 1'b0;
      end else begin
        cnt <= cnt - PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/soc_system_step_gen.sv
// Avalon-MM step/direction pulse generator for one stepper axis.
module soc_system_step_gen
  import soc_system_step_gen_pkg::*;
#(
  parameter int COUNT_W   = 16,
  parameter int PERIOD_W  = 16,
  parameter int DIR_SETUP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        step_out,
  output logic        dir_out,
  output logic        enable_out
);

  state_t              state;
  state_t              state_nxt;
  logic                dir_reg;
  logic                done;
  logic [PERIOD_W-1:0] half;
  logic [PERIOD_W-1:0] half_eff;
  logic [COUNT_W-1:0]  remaining;
  logic [COUNT_W-1:0]  steps_done;
  logic                busy;
  logic                wr_ctrl, wr_half, wr_count, wr_abort;
  logic                start, abort;
  logic                tmr_load, tmr_expire;
  logic [PERIOD_W-1:0] tmr_value;
  logic                step_fall, finish;
  logic [31:0]         ctrl_word;
  logic                unused_wd;

  assign unused_wd = &{1'b0, writedata};

  assign wr_ctrl  = chipselect && write && (address == ADDR_CTRL);
  assign wr_half  = chipselect && write && (address == ADDR_HALF);
  assign wr_count = chipselect && write && (address == ADDR_COUNT);
  assign wr_abort = chipselect && write && (address == ADDR_ABORT);

  assign busy     = (state != ST_IDLE);
  assign half_eff = (half == '0) ? PERIOD_W'(1) : half;
  // Clearing enable during a move stops it the same way an ABORT write does.
  assign abort    = wr_abort || (wr_ctrl && busy && !writedata[CTRL_EN_BIT]);
  assign start    = wr_count && !busy && enable_out && (writedata[COUNT_W-1:0] != '0);

  soc_system_step_phase_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (tmr_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus phase-timer reload and step bookkeeping strobes.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_value = half_eff;
    step_fall = 1'b0;
    finish    = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (DIR_SETUP == 0)) begin
            state_nxt = ST_HIGH;
            tmr_load  = 1'b1;
          end else if (start) begin
            state_nxt = ST_SETUP;
            tmr_load  = 1'b1;
            tmr_value = PERIOD_W'(DIR_SETUP);
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (tmr_expire) begin
            state_nxt = ST_HIGH;
            tmr_load  = 1'b1;
          end else begin
            state_nxt = ST_SETUP;
          end
        end
        ST_HIGH: begin
          if (tmr_expire) begin
            state_nxt = ST_LOW;
            tmr_load  = 1'b1;
            step_fall = 1'b1;
          end else begin
            state_nxt = ST_HIGH;
          end
        end
        ST_LOW: begin
          if (tmr_expire && (remaining != '0)) begin
            state_nxt = ST_HIGH;
            tmr_load  = 1'b1;
          end else if (tmr_expire) begin
            state_nxt = ST_IDLE;
            finish    = 1'b1;
          end else begin
            state_nxt = ST_LOW;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Register file, move counters and the done flag (set beats W1C clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_reg    <= 1'b0;
      enable_out <= 1'b0;
      dir_out    <= 1'b0;
      half       <= PERIOD_W'(1);
      remaining  <= '0;
      steps_done <= '0;
      done       <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        dir_reg    <= writedata[CTRL_DIR_BIT];
        enable_out <= writedata[CTRL_EN_BIT];
      end
      if (wr_half && !busy) begin
        half <= writedata[PERIOD_W-1:0];
      end
      if (start) begin
        dir_out    <= dir_reg;
        remaining  <= writedata[COUNT_W-1:0];
        steps_done <= '0;
      end else if (abort) begin
        remaining <= '0;
      end else if (step_fall) begin
        remaining  <= remaining - COUNT_W'(1);
        steps_done <= steps_done + COUNT_W'(1);
      end
      if (start) begin
        done <= 1'b0;
      end else if (abort || finish) begin
        done <= 1'b1;
      end else if (wr_ctrl && writedata[CTRL_DONE_BIT]) begin
        done <= 1'b0;
      end
    end
  end

  // Step pin follows the HIGH phase one edge later; an abort drops it at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_out <= 1'b0;
    end else begin
      step_out <= (state == ST_HIGH) && !abort;
    end
  end

  // Assemble the CTRL/STATUS read word.
  always_comb begin
    ctrl_word                = '0;
    ctrl_word[CTRL_DIR_BIT]  = dir_out;
    ctrl_word[CTRL_EN_BIT]   = enable_out;
    ctrl_word[CTRL_BUSY_BIT] = busy;
    ctrl_word[CTRL_DONE_BIT] = done;
  end

  // Registered read mux, refreshed every edge from address.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      case (address)
        ADDR_CTRL:  readdata <= ctrl_word;
        ADDR_HALF:  readdata <= 32'(half);
        ADDR_COUNT: readdata <= 32'(remaining);
        ADDR_ABORT: readdata <= 32'(steps_done);
        default:    readdata <= '0;
      endcase
    end
  end

endmodule
